// File: rtl/resonant_pkg.sv
// Shared types and default constants for the resonant emulator control path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package resonant_pkg;

    localparam int BUS_WIDTH_DEF      = 10;
    localparam int PULSE_DURATION_DEF = 3;
    localparam int Q_PER_PULSE_DEF    = 60;
    localparam int WINDOW_CYCLES_DEF  = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } q_cnt_state_e;

endpackage

// File: rtl/pulse_qualifier.sv
// Synchronizes an async pulse train and accepts each high run once it lasts MIN_HIGH cycles.
// Latency: input rise to accept is SYNC_STAGES+MIN_HIGH-1 cycles.
// Backpressure: none; accept is a free-running single-cycle strobe.
module pulse_qualifier
    import resonant_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HIGH    = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic accept
);

    localparam int RUN_W = $clog2(MIN_HIGH + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MIN_HIGH);
    localparam logic [RUN_W-1:0] RUN_HIT = RUN_W'(MIN_HIGH - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [RUN_W-1:0]       run;
    logic                   d_sync;

    assign d_sync = sync[SYNC_STAGES-1];

    // run holds the length of the high run seen before this cycle, saturating at MIN_HIGH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            run  <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d_async};
            if (!d_sync) begin
                run <= '0;
            end else if (run != RUN_MAX) begin
                run <= run + RUN_W'(1);
            end
        end
    end

    assign accept = d_sync && (run == RUN_HIT);

endmodule

// File: rtl/q_pulse_counter.sv
// Counts qualified charge pulses over back-to-back fixed windows and reports each window's count.
// Latency: result valid 1 cycle after the last COUNT cycle of a window.
// Backpressure: result held in DONE until q_ready; no new window starts before the handshake.
module q_pulse_counter
    import resonant_pkg::*;
#(
    parameter int BUS_WIDTH     = BUS_WIDTH_DEF,
    parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEF,
    parameter int SYNC_STAGES   = 2,
    parameter int MIN_HIGH      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 q_serialized,
    input  logic                 start,
    output logic [BUS_WIDTH-1:0] q_count,
    output logic                 q_valid,
    input  logic                 q_ready,
    output logic                 q_ovf,
    output logic                 busy
);

    localparam int WIN_W = $clog2(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [BUS_WIDTH-1:0] ACC_MAX  = '1;

    q_cnt_state_e         state;
    logic [BUS_WIDTH-1:0] acc;
    logic [BUS_WIDTH-1:0] acc_next;
    logic [WIN_W-1:0]     win;
    logic                 ovf_int;
    logic                 ovf_next;
    logic                 accept;

    pulse_qualifier #(
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_HIGH    (MIN_HIGH)
    ) u_qual (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_async (q_serialized),
        .accept  (accept)
    );

    // Saturating accumulate; an accept that cannot be counted marks the window as overflowed
    always_comb begin
        acc_next = acc;
        ovf_next = ovf_int;
        if (accept) begin
            if (acc == ACC_MAX) begin
                ovf_next = 1'b1;
            end else begin
                acc_next = acc + BUS_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            win     <= '0;
            ovf_int <= 1'b0;
            q_count <= '0;
            q_ovf   <= 1'b0;
            q_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= COUNT;
                        acc     <= '0;
                        win     <= '0;
                        ovf_int <= 1'b0;
                    end
                end
                COUNT: begin
                    if (!start) begin
                        state <= IDLE;
                    end else begin
                        acc     <= acc_next;
                        ovf_int <= ovf_next;
                        win     <= win + WIN_W'(1);
                        if (win == WIN_LAST) begin
                            state   <= DONE;
                            q_count <= acc_next;
                            q_ovf   <= ovf_next;
                            q_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // accepts arriving here are intentionally dropped
                    if (q_ready) begin
                        q_valid <= 1'b0;
                        if (start) begin
                            state   <= COUNT;
                            acc     <= '0;
                            win     <= '0;
                            ovf_int <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == COUNT);

endmodule

// File: tb/tb_q_pulse_counter.sv
// Bench for q_pulse_counter: a 10-bit and a 4-bit instance share stimulus;
// expected window results are queued by the stimulus and popped by a negedge monitor.
module tb_q_pulse_counter;

    localparam int WIN = 256;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       q_serialized;
    logic       start;
    logic       q_ready;
    logic [9:0] q_count;
    logic       q_valid;
    logic       q_ovf;
    logic       busy;
    logic [3:0] q_count4;
    logic       q_valid4;
    logic       q_ovf4;
    logic       busy4;

    typedef struct {
        int cnt;
        int ovf;
        int cnt4;
        int ovf4;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    q_pulse_counter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .q_serialized (q_serialized),
        .start        (start),
        .q_count      (q_count),
        .q_valid      (q_valid),
        .q_ready      (q_ready),
        .q_ovf        (q_ovf),
        .busy         (busy)
    );

    q_pulse_counter #(.BUS_WIDTH(4)) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .q_serialized (q_serialized),
        .start        (start),
        .q_count      (q_count4),
        .q_valid      (q_valid4),
        .q_ready      (q_ready),
        .q_ovf        (q_ovf4),
        .busy         (busy4)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input int o, input int c4, input int o4);
        exp_t e;
        e.cnt  = c;
        e.ovf  = o;
        e.cnt4 = c4;
        e.ovf4 = o4;
        exp_q.push_back(e);
    endtask

    task automatic pulses(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            q_serialized = 1'b1;
            tick(hi);
            q_serialized = 1'b0;
            tick(lo);
        end
    endtask

    task automatic wait_busy(input string tag);
        int k = 0;
        while (!busy && k < 20) begin
            tick(1);
            k++;
        end
        check({tag, "_busy"}, busy, 1);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!q_valid && k < 400) begin
            tick(1);
            k++;
        end
        check({tag, "_valid_timeout"}, q_valid, 1);
    endtask

    // Monitor: checks each result on q_valid rise, its stability while held, and window length
    bit pv = 1'b0, pv4 = 1'b0, pend_b2b = 1'b0;
    int brun = 0, brun4 = 0;
    always @(negedge clk) begin
        if (pend_b2b) begin
            check("b2b_busy", busy, 1);
            check("b2b_busy4", busy4, 1);
            pend_b2b = 1'b0;
        end
        if ((q_valid && !pv) || (q_valid4 && !pv4)) begin
            check("result_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                check("valid", q_valid, 1);
                check("valid4", q_valid4, 1);
                check("count", q_count, cur.cnt);
                check("ovf", q_ovf, cur.ovf);
                check("count4", q_count4, cur.cnt4);
                check("ovf4", q_ovf4, cur.ovf4);
                check("window_len", brun, WIN);
                check("window_len4", brun4, WIN);
            end
        end else begin
            if (q_valid && pv) begin
                check("hold_count", q_count, cur.cnt);
                check("hold_ovf", q_ovf, cur.ovf);
                check("hold_busy", busy, 0);
            end
            if (q_valid4 && pv4) begin
                check("hold_count4", q_count4, cur.cnt4);
                check("hold_ovf4", q_ovf4, cur.ovf4);
                check("hold_busy4", busy4, 0);
            end
        end
        if (q_valid && q_ready && start) pend_b2b = 1'b1;
        brun  = busy  ? brun + 1  : 0;
        brun4 = busy4 ? brun4 + 1 : 0;
        pv    = q_valid;
        pv4   = q_valid4;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        q_serialized = 1'b0;
        q_ready      = 1'b1;
        tick(3);
        check("rst_count", q_count, 0);
        check("rst_valid", q_valid, 0);
        check("rst_ovf", q_ovf, 0);
        check("rst_busy", busy, 0);
        check("rst_count4", q_count4, 0);
        check("rst_busy4", busy4, 0);
        rst_n = 1'b1;
        tick(2);

        // clean counting
        push(10, 0, 10, 0);
        start = 1'b1;
        wait_busy("w1");
        tick(5);
        pulses(10, 3, 3);
        wait_valid("w1");

        // glitch rejection
        push(4, 0, 4, 0);
        wait_busy("w2");
        tick(5);
        for (int i = 0; i < 5; i++) begin
            pulses(1, 1, 3);
            if (i < 4) pulses(1, 3, 3);
        end
        wait_valid("w2");

        // saturation on the 4-bit instance, then recovery
        push(20, 0, 15, 1);
        wait_busy("w3");
        tick(5);
        pulses(20, 3, 3);
        wait_valid("w3");

        push(3, 0, 3, 0);
        wait_busy("w4");
        tick(5);
        pulses(3, 3, 3);
        wait_valid("w4");

        // backpressure, then back-to-back release
        push(7, 0, 7, 0);
        wait_busy("w5");
        q_ready = 1'b0;
        tick(5);
        pulses(7, 3, 3);
        wait_valid("w5");
        tick(50);
        q_ready = 1'b1;
        tick(1);

        push(5, 0, 5, 0);
        wait_busy("w6");
        tick(5);
        pulses(5, 3, 3);
        wait_valid("w6");

        // abort at win=100 after 6 accepts
        wait_busy("w7");
        tick(5);
        pulses(6, 3, 3);
        tick(59);
        start = 1'b0;
        tick(2);
        check("abort_busy", busy, 0);
        check("abort_busy4", busy4, 0);
        tick(300);
        check("abort_valid", q_valid, 0);

        push(4, 0, 4, 0);
        start = 1'b1;
        wait_busy("restart");
        tick(5);
        pulses(4, 3, 3);
        wait_valid("restart");

        // asynchronous reset at win=40
        wait_busy("w9");
        tick(5);
        pulses(5, 3, 3);
        tick(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_count", q_count, 0);
        check("midrst_valid", q_valid, 0);
        check("midrst_ovf", q_ovf, 0);
        check("midrst_busy", busy, 0);
        check("midrst_busy4", busy4, 0);
        tick(3);
        rst_n = 1'b1;

        push(6, 0, 6, 0);
        wait_busy("post_rst");
        tick(5);
        pulses(6, 3, 3);
        wait_valid("post_rst");
        start = 1'b0;
        tick(5);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/q_pulse_counter.md
Name: q_pulse_counter

Overview:
- Downstream consumer of the resonant system emulator's serialized charge output (q_serialized).
- Synchronizes and glitch-filters the charge-quantum pulse train, then counts accepted pulses over a fixed measurement window.
- Presents the count as a BUS_WIDTH word, comparable to i_ref, on a valid/ready handshake for the control loop.

Parameters:
- BUS_WIDTH, 10, width of the count word; matches the i_ref width.
- WINDOW_CYCLES, 256, measurement window length in clk cycles; must be at least 2.
- SYNC_STAGES, 2, synchronizer depth on q_serialized; must be at least 2.
- MIN_HIGH, 2, consecutive synchronized-high cycles required to accept a pulse; must be at least 1.

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- q_serialized  in  1  charge pulse train from the emulator; asynchronous to clk.
- start  in  1  level enable; while high, windows run back-to-back.
- q_count  out  BUS_WIDTH  accepted-pulse count of the last completed window.
- q_valid  out  1  q_count and q_ovf are valid.
- q_ready  in  1  consumer accepts the result.
- q_ovf  out  1  the window count saturated.
- busy  out  1  a window is in progress.

Behaviour:
Reset:
- rst_n low clears all state immediately, including synchronizer flops and filter counter.
- Outputs: q_count=0, q_valid=0, q_ovf=0, busy=0. FSM goes to IDLE.
- Reset mid-window discards the partial count; no result is produced.

Pulse qualification:
- q_serialized passes through SYNC_STAGES flops, then a high-run counter.
- A pulse is accepted exactly once, in the cycle its run reaches MIN_HIGH. A low cycle clears the run.
- Runs shorter than MIN_HIGH are ignored.
- Input rise to accept latency is SYNC_STAGES+MIN_HIGH-1 cycles.

FSM states: IDLE, COUNT, DONE.
- IDLE: busy=0. start=1 moves to COUNT next cycle, with acc=0, win=0, ovf_int=0.
- COUNT: busy=1. win increments every cycle. An accept increments acc.
  - acc saturates at 2^BUS_WIDTH-1; an accept at saturation sets ovf_int.
  - At win==WINDOW_CYCLES-1, the FSM moves to DONE. An accept in that last cycle is included.
  - On the same edge: q_count<=acc (final), q_ovf<=ovf_int, q_valid<=1.
  - start=0 during COUNT aborts to IDLE. No result is produced and q_valid stays 0.
- DONE: busy=0. q_count, q_ovf and q_valid are held stable until q_valid&&q_ready.
  - Handshake with start=1: q_valid<=0 and a new window starts (COUNT, counters cleared) on the next cycle.
  - Handshake with start=0: q_valid<=0 and the FSM goes to IDLE.
  - start changes while in DONE are ignored until the handshake.
  - Accepts during DONE are dropped. The filter keeps running, so a pulse straddling the window boundary is counted at most once.
- q_ready is ignored while q_valid=0.
- Window length is exactly WINDOW_CYCLES COUNT cycles. The result appears 1 cycle after the last COUNT cycle.
- Arithmetic: acc and q_count are unsigned BUS_WIDTH. win has width $clog2(WINDOW_CYCLES). The run counter has width $clog2(MIN_HIGH+1) and saturates at MIN_HIGH.

Decomposition:
Shared package resonant_pkg holds:
- the q_cnt_state_e enum (IDLE, COUNT, DONE);
- default constants BUS_WIDTH_DEF=10, PULSE_DURATION_DEF=3, Q_PER_PULSE_DEF=60, WINDOW_CYCLES_DEF=256.

Sub-module pulse_qualifier:
- Contains the synchronizer and high-run filter.
- Ports: clk, rst_n, d_async, accept (1-cycle pulse).
- Parameters: SYNC_STAGES, MIN_HIGH.

Top level holds the FSM, counters and output registers.

Test Plan:
- Clean counting: start=1; 10 pulses, each 3 high / 3 low cycles, inside one window -> q_count=10, q_ovf=0, q_valid exactly 1 cycle after the 256th COUNT cycle.
- Glitch rejection: 5 one-cycle highs interleaved with 4 three-cycle pulses -> q_count=4.
- Saturation: BUS_WIDTH=4; 20 pulses (3 high / 3 low) in one window -> q_count=15, q_ovf=1. Next window with 3 pulses -> q_count=3, q_ovf=0.
- Backpressure and back-to-back: q_ready=0 for 50 cycles after q_valid -> q_count/q_ovf stable, no new window starts. q_ready=1 with start=1 -> busy rises the next cycle, second window result is correct.
- Abort: start dropped at win=100 with 6 pulses accepted -> IDLE, q_valid never rises. Restart -> new count starts from 0.
- Reset mid-window: rst_n low asynchronously at win=40 -> all outputs 0 immediately. After release with start held 1 -> a full 256-cycle window runs, count covers only post-reset pulses.
